iir_biquad_seq: RTL and testbench

Parametrised second-order (biquad) IIR filter, Direct Form I, with signed data and run-time programmable coefficients. One shared multiplier is time-multiplexed over the five taps by a small FSM. Samples arrive on a valid/ready input stream and leave on a valid/ready output stream. The block sits behind a sample-rate strobe or source and replaces fixed-coefficient, unsigned filter stages.

---
 rtl/iir_biquad_seq_if.sv | 31 +++
 rtl/iir_biquad_seq.sv | 190 +++++++++++++++++++
 tb/tb_iir_biquad_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/iir_biquad_seq_if.sv
// Stream and configuration bundle for the sequential biquad.
// Widths must match the parameters of the attached filter.
interface iir_biquad_seq_if #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 12
);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sat;
  logic                 cfg_we;
  logic [2:0]           cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 state_clr;

  modport master (
    output in_data, in_valid, out_ready,
    output cfg_we, cfg_addr, cfg_data, state_clr,
    input  in_ready, out_data, out_valid, out_sat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    input  cfg_we, cfg_addr, cfg_data, state_clr,
    output in_ready, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// Direct Form I biquad with one multiplier shared over five taps.
// Rounded, saturated output feeds back into the y delay line.
module iir_biquad_seq #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int FRAC = 6,
  parameter int OW   = 12,
  parameter int ACCW = OW + CW + 3
) (
  input  logic               clk,
  input  logic               rst,
  iir_biquad_seq_if.slave    bus
);

  localparam int PW = OW + CW;
  localparam logic signed [ACCW-1:0] HALF =
    ACCW'(2 ** (FRAC - 1));
  localparam logic signed [CW-1:0] ONE =
    CW'(2 ** FRAC);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DW-1:0]   r_x0;
  logic signed [DW-1:0]   r_x1;
  logic signed [DW-1:0]   r_x2;
  logic signed [OW-1:0]   r_y1;
  logic signed [OW-1:0]   r_y2;
  logic signed [CW-1:0]   r_b0;
  logic signed [CW-1:0]   r_b1;
  logic signed [CW-1:0]   r_b2;
  logic signed [CW-1:0]   r_a1;
  logic signed [CW-1:0]   r_a2;
  logic [2:0]             r_k;
  logic signed [ACCW-1:0] r_acc;
  logic signed [OW-1:0]   r_out_data;
  logic                   r_out_sat;

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_cfg;
  logic                   w_clr;
  logic                   w_in_ready;
  logic                   w_out_valid;

  logic signed [OW-1:0]   w_opnd;
  logic signed [CW-1:0]   w_coef;
  logic                   w_neg;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_acc_nx;
  logic signed [ACCW-1:0] w_rnd;
  logic signed [ACCW-1:0] w_shr;
  logic [ACCW-OW:0]       w_hi;
  logic                   w_ovf;
  logic signed [OW-1:0]   w_y;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (bus.in_valid) w_next = MAC;
      MAC:   if (r_k == 3'd4) w_next = ROUND;
      ROUND: w_next = OUT;
      OUT:   if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_idle      = (r_state == IDLE);
    w_in_ready  = w_idle;
    w_out_valid = (r_state == OUT);
    w_accept    = w_idle && bus.in_valid;
    w_cfg       = w_idle && bus.cfg_we;
    w_clr       = w_idle && bus.state_clr;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  // Feedback taps subtract, so the a-coefficients keep their natural sign.
  always_comb begin
    w_opnd = '0;
    w_coef = '0;
    w_neg  = 1'b0;
    case (r_k)
      3'd0: begin w_opnd = OW'(r_x0); w_coef = r_b0; end
      3'd1: begin w_opnd = OW'(r_x1); w_coef = r_b1; end
      3'd2: begin w_opnd = OW'(r_x2); w_coef = r_b2; end
      3'd3: begin
        w_opnd = r_y1;
        w_coef = r_a1;
        w_neg  = 1'b1;
      end
      3'd4: begin
        w_opnd = r_y2;
        w_coef = r_a2;
        w_neg  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_prod   = w_opnd * w_coef;
  assign w_term   = ACCW'(w_prod);
  assign w_acc_nx = w_neg ? r_acc - w_term
                          : r_acc + w_term;

  // Round half up, then clip anything that will not fit in OW bits.
  assign w_rnd = r_acc + HALF;
  assign w_shr = w_rnd >>> FRAC;
  assign w_hi  = w_shr[ACCW-1:OW-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_y = w_shr[OW-1:0];
    if (w_ovf) begin
      if (w_shr[ACCW-1]) w_y = {1'b1, {(OW-1){1'b0}}};
      else               w_y = {1'b0, {(OW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      r_b0       <= ONE;
      r_b1       <= '0;
      r_b2       <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      if (w_cfg) begin
        case (bus.cfg_addr)
          3'd0: r_b0 <= bus.cfg_data;
          3'd1: r_b1 <= bus.cfg_data;
          3'd2: r_b2 <= bus.cfg_data;
          3'd3: r_a1 <= bus.cfg_data;
          3'd4: r_a2 <= bus.cfg_data;
          default: ;
        endcase
      end
      if (w_clr) begin
        r_x1 <= '0;
        r_x2 <= '0;
        r_y1 <= '0;
        r_y2 <= '0;
      end
      if (w_accept) begin
        r_x0  <= bus.in_data;
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= w_acc_nx;
        r_k   <= r_k + 3'd1;
      end
      if (r_state == ROUND) begin
        r_out_data <= w_y;
        r_out_sat  <= w_ovf;
        r_x2       <= r_x1;
        r_x1       <= r_x0;
        r_y2       <= r_y1;
        r_y1       <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed bench for iir_biquad_seq with a scoreboard queue
// of expected outputs and immediate assertions.
module tb_iir_biquad_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  iir_biquad_seq_if #(.DW(8), .CW(8), .OW(12)) bus ();

  iir_biquad_seq #(
    .DW(8), .CW(8), .FRAC(6), .OW(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int d;
    bit s;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp_v);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a,
                        input logic signed [7:0] v);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = v;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.state_clr = 1'b1;
    @(negedge clk);
    bus.state_clr = 1'b0;
  endtask

  task automatic do_sample(input logic signed [7:0] x,
                           input int exp_d,
                           input bit exp_s,
                           input int stall,
                           input bit clr,
                           input bit wcfg,
                           input logic [2:0] wa,
                           input logic signed [7:0] wd);
    int cyc;
    exp_t e;
    logic signed [11:0] held;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_data   = x;
    bus.in_valid  = 1'b1;
    bus.state_clr = clr;
    bus.cfg_we    = wcfg;
    bus.cfg_addr  = wa;
    bus.cfg_data  = wd;
    bus.out_ready = (stall == 0);
    e.d = exp_d;
    e.s = exp_s;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.state_clr = 1'b0;
    bus.cfg_we    = 1'b0;
    chk("busy_ready", bus.in_ready, 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, 6);
    e = q.pop_front();
    chk("out_data", bus.out_data, e.d);
    chk("out_sat", bus.out_sat, e.s);
    if (stall > 0) begin
      held = bus.out_data;
      for (int i = 0; i < stall; i++) begin
        bus.cfg_we   = (i == 2);
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'sd0;
        @(posedge clk);
        #1;
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held);
        chk("stall_ready", bus.in_ready, 0);
      end
      bus.cfg_we    = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid_drop", bus.out_valid, 0);
  endtask

  task automatic smp(input logic signed [7:0] x,
                     input int exp_d,
                     input bit exp_s);
    do_sample(x, exp_d, exp_s, 0, 1'b0, 1'b0, 3'd0, 8'sd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int seen;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.state_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);

    smp(8'sd37, 37, 1'b0);
    smp(-8'sd100, -100, 1'b0);

    cfg_wr(3'd1, 8'sd64);
    cfg_wr(3'd2, 8'sd64);
    do_clr();
    smp(8'sd50, 50, 1'b0);
    smp(8'sd0, 50, 1'b0);
    smp(8'sd0, 50, 1'b0);
    smp(8'sd0, 0, 1'b0);

    cfg_wr(3'd1, 8'sd0);
    cfg_wr(3'd2, 8'sd0);
    cfg_wr(3'd3, -8'sd32);
    do_clr();
    smp(8'sd40, 40, 1'b0);
    smp(8'sd0, 20, 1'b0);
    smp(8'sd0, 10, 1'b0);
    smp(8'sd0, 5, 1'b0);
    smp(8'sd0, 3, 1'b0);
    smp(8'sd0, 2, 1'b0);

    cfg_wr(3'd3, -8'sd64);
    do_clr();
    for (int n = 1; n <= 18; n++) begin
      v = 127 * n;
      if (v > 2047) smp(8'sd127, 2047, 1'b1);
      else          smp(8'sd127, v, 1'b0);
    end
    do_clr();
    for (int n = 1; n <= 17; n++) begin
      v = -128 * n;
      if (v < -2048) smp(-8'sd128, -2048, 1'b1);
      else           smp(-8'sd128, v, 1'b0);
    end

    cfg_wr(3'd3, 8'sd0);
    do_clr();
    do_sample(8'sd10, 10, 1'b0, 10, 1'b0, 1'b0, 3'd0, 8'sd0);
    smp(8'sd20, 20, 1'b0);

    do_sample(-8'sd5, -2, 1'b0, 0, 1'b1, 1'b1, 3'd0, 8'sd32);
    smp(8'sd5, 3, 1'b0);
    cfg_wr(3'd0, 8'sd64);

    cfg_wr(3'd1, 8'sd64);
    @(negedge clk);
    bus.in_data  = 8'sd50;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_ready", bus.in_ready, 1);
    smp(8'sd37, 37, 1'b0);
    smp(8'sd5, 5, 1'b0);

    cfg_wr(3'd3, -8'sd32);
    do_clr();
    smp(8'sd40, 40, 1'b0);
    smp(8'sd0, 20, 1'b0);
    do_clr();
    smp(8'sd8, 8, 1'b0);
    smp(8'sd0, 4, 1'b0);
    do_sample(8'sd8, 8, 1'b0, 0, 1'b1, 1'b0, 3'd0, 8'sd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
